// File: rtl/regfile_write_queue_if.sv
// rtl/regfile_write_queue_if.sv - producer, register-file write port and forwarding signals of the write queue
interface regfile_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              port_grant;
  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_rs1;
  logic [ADDR_W-1:0] fwd_rs2;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [CW-1:0]     count;

  modport slave (
    input  in_valid, in_rd, in_data, port_grant, fwd_rs1, fwd_rs2,
    output in_ready, RegWrite, rd, write_data,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );

  modport master (
    output in_valid, in_rd, in_data, port_grant, fwd_rs1, fwd_rs2,
    input  in_ready, RegWrite, rd, write_data,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );
endinterface

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - writeback FIFO draining into the register file with read forwarding
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  regfile_write_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;

  logic empty;
  logic full;
  logic pop;
  logic push;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = !empty && bus.port_grant;
  // x0 writes complete the handshake but are dropped here
  assign push  = bus.in_valid && bus.in_ready && (bus.in_rd != '0);

  assign bus.in_ready   = !full || pop;
  assign bus.RegWrite   = pop;
  assign bus.rd         = empty ? '0 : rd_q[head];
  assign bus.write_data = empty ? '0 : data_q[head];
  assign bus.count      = cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        rd_q[tail]   <= bus.in_rd;
        data_q[tail] <= bus.in_data;
        tail         <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    bus.fwd_hit1  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        if ((bus.fwd_rs1 != '0) && (rd_q[head + PW'(i)] == bus.fwd_rs1)) begin
          bus.fwd_hit1  = 1'b1;
          bus.fwd_data1 = data_q[head + PW'(i)];
        end
        if ((bus.fwd_rs2 != '0) && (rd_q[head + PW'(i)] == bus.fwd_rs2)) begin
          bus.fwd_hit2  = 1'b1;
          bus.fwd_data2 = data_q[head + PW'(i)];
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - scoreboard bench for regfile_write_queue against a queue/array register file model
module tb_regfile_write_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  regfile_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] model_rf [32];
  logic [DATA_W-1:0] dut_rf   [32];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void newest(input logic [ADDR_W-1:0] rs, output logic hit,
                                 output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].rd == rs) begin
          hit = 1'b1;
          d   = exp_q[i].data;
        end
      end
    end
  endfunction

  always @(negedge CLK) begin
    logic              h;
    logic [DATA_W-1:0] d;
    logic              we;
    if (!RST) begin
      newest(bus.fwd_rs1, h, d);
      check("fwd_hit1", 64'(bus.fwd_hit1), 64'(h));
      check("fwd_data1", bus.fwd_data1, d);
      newest(bus.fwd_rs2, h, d);
      check("fwd_hit2", 64'(bus.fwd_hit2), 64'(h));
      check("fwd_data2", bus.fwd_data2, d);
      we = (exp_q.size() > 0) && bus.port_grant;
      check("RegWrite", 64'(bus.RegWrite), 64'(we));
      if (we) begin
        check("rd", 64'(bus.rd), 64'(exp_q[0].rd));
        check("write_data", bus.write_data, exp_q[0].data);
        dut_rf[bus.rd] = bus.write_data;
        void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        check("rd_idle", 64'(bus.rd), 64'd0);
        check("write_data_idle", bus.write_data, 64'd0);
      end
    end
  end

  task automatic cycle(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                       input logic g, input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2);
    int   n;
    logic exp_ready;
    logic fire;
    bus.in_valid   = v;
    bus.in_rd      = r;
    bus.in_data    = d;
    bus.port_grant = g;
    bus.fwd_rs1    = rs1;
    bus.fwd_rs2    = rs2;
    #2;
    n         = exp_q.size();
    exp_ready = (n < DEPTH) || (g && n > 0);
    check("count", 64'(bus.count), 64'(n));
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    fire = v && exp_ready;
    @(posedge CLK);
    if (fire && r != 0) begin
      exp_q.push_back('{rd: r, data: d});
      model_rf[r] = d;
    end
    #1;
  endtask

  task automatic clear_models();
    exp_q.delete();
    foreach (model_rf[i]) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] r;
    bus.in_valid   = 1'b0;
    bus.in_rd      = '0;
    bus.in_data    = '0;
    bus.port_grant = 1'b0;
    bus.fwd_rs1    = '0;
    bus.fwd_rs2    = '0;
    clear_models();
    #2;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_fwd_hit1", 64'(bus.fwd_hit1), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // reset mid-stream with three writes queued
    cycle(1, 5'd3, 64'hA1, 0, 5'd3, 5'd4);
    cycle(1, 5'd4, 64'hA2, 0, 5'd3, 5'd4);
    cycle(1, 5'd5, 64'hA3, 0, 5'd3, 5'd4);
    bus.in_valid = 1'b0;
    bus.port_grant = 1'b1;
    #1 RST = 1'b1;
    #1;
    check("midrst_count", 64'(bus.count), 64'd0);
    check("midrst_RegWrite", 64'(bus.RegWrite), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_fwd_hit1", 64'(bus.fwd_hit1), 64'd0);
    clear_models();
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) cycle(0, 5'd0, 64'd0, 1, 5'd3, 5'd5);

    // single write
    cycle(1, 5'd5, 64'hDEAD, 1, 5'd5, 5'd0);
    cycle(0, 5'd0, 64'd0, 1, 5'd5, 5'd0);
    cycle(0, 5'd0, 64'd0, 1, 5'd5, 5'd0);

    // fill with grant low, held 5th push, then push+pop across pointer wrap
    for (int i = 1; i <= 4; i++) cycle(1, 5'(i), 64'(32'h100 + i), 0, 5'd2, 5'd4);
    cycle(1, 5'd6, 64'h106, 0, 5'd2, 5'd6);
    cycle(1, 5'd6, 64'h106, 0, 5'd2, 5'd6);
    cycle(1, 5'd6, 64'h106, 1, 5'd2, 5'd6);
    for (int i = 7; i <= 10; i++) cycle(1, 5'(i), 64'(32'h100 + i), 1, 5'd6, 5'd8);
    repeat (6) cycle(0, 5'd0, 64'd0, 1, 5'd9, 5'd10);

    // forwarding picks the youngest matching entry
    cycle(1, 5'd7, 64'h11, 0, 5'd7, 5'd0);
    cycle(1, 5'd7, 64'h22, 0, 5'd7, 5'd0);
    cycle(0, 5'd0, 64'd0, 0, 5'd7, 5'd0);
    cycle(0, 5'd0, 64'd0, 0, 5'd7, 5'd9);
    repeat (3) cycle(0, 5'd0, 64'd0, 1, 5'd7, 5'd9);

    // x0 write completes but is not stored
    cycle(1, 5'd0, 64'hFF, 1, 5'd0, 5'd1);
    cycle(0, 5'd0, 64'd0, 1, 5'd0, 5'd1);
    cycle(0, 5'd0, 64'd0, 1, 5'd0, 5'd1);

    // random traffic and grant
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), r, {$urandom, $urandom}, ($urandom_range(0, 9) < 6),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) cycle(0, 5'd0, 64'd0, 1, 5'd0, 5'd0);
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    cycle(0, 5'd0, 64'd0, 1, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) check($sformatf("rf[%0d]", i), dut_rf[i], model_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
